// File: rtl/hs32_exec_stage.sv
// ---------------------------------------------------------------------------
// hs32_exec_stage
//
// Purpose:
//   Two-stage execute block for the HS32 core. S0 holds the issued operands
//   and drives an external combinational ALU. S1 holds the ALU result until
//   the writeback port takes it. The architectural nzcv flags register is
//   updated when an operation leaves S0, so the next operation already sees
//   the new flags on alu_fl_o.
//
// Configuration:
//   HS32_EXEC_SHIFT_EN  defined   -> operand-B barrel shifter (LSL/LSR/ASR/ROR)
//                       undefined -> alu_b_o = S0.b; shdir_i/shamt_i ignored
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   valid_i / ready_o        issue handshake from decode
//   op_i, a_i, b_i, rd_i     ALU code, operands, destination register
//   wb_en_i, fl_we_i         writeback enable, flags write enable
//   shdir_i, shamt_i         operand-B shift direction and amount
//   flush_i                  drop every in-flight operation
//   alu_a_o, alu_b_o,
//   alu_op_o, alu_fl_o       operands, op code and current flags to the ALU
//   alu_r_i, alu_fl_i        ALU result and resulting flags
//   wb_valid_o / wb_ready_i  writeback handshake
//   wb_rd_o, wb_data_o       writeback destination and data
//   flags_o                  architectural nzcv register
// ---------------------------------------------------------------------------
module hs32_exec_stage #(
    parameter logic [3:0] FLAGS_RST = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [3:0]  rd_i,
    input  logic        wb_en_i,
    input  logic        fl_we_i,
    input  logic [1:0]  shdir_i,
    input  logic [4:0]  shamt_i,
    input  logic        flush_i,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [3:0]  alu_op_o,
    output logic [3:0]  alu_fl_o,
    input  logic [31:0] alu_r_i,
    input  logic [3:0]  alu_fl_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [3:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic [3:0]  flags_o
);

    // S0: operand register
    logic        r_s0_valid;
    logic [3:0]  r_s0_op;
    logic [31:0] r_s0_a;
    logic [31:0] r_s0_b;
    logic [3:0]  r_s0_rd;
    logic        r_s0_wb_en;
    logic        r_s0_fl_we;

    // S1: result register
    logic        r_s1_valid;
    logic [31:0] r_s1_data;
    logic [3:0]  r_s1_rd;

    logic [3:0]  r_flags;

    logic        w_s0_adv;
    logic        w_accept;
    logic        w_wb_fire;
    logic [31:0] w_b_shifted;

    // S0 may leave when it needs no S1 slot, or S1 is free, or S1 drains now.
    assign w_s0_adv  = r_s0_valid && (!r_s0_wb_en || !r_s1_valid || wb_ready_i);
    assign ready_o   = !flush_i && (!r_s0_valid || w_s0_adv);
    assign w_accept  = valid_i && ready_o;
    assign w_wb_fire = r_s1_valid && wb_ready_i;

`ifdef HS32_EXEC_SHIFT_EN
    logic [1:0] r_s0_shdir;
    logic [4:0] r_s0_shamt;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_b_shifted = r_s0_b;
        case (r_s0_shdir)
            2'd0: w_b_shifted = r_s0_b << r_s0_shamt;
            2'd1: w_b_shifted = r_s0_b >> r_s0_shamt;
            2'd2: w_b_shifted = $unsigned($signed(r_s0_b) >>> r_s0_shamt);
            // A left shift by 32 yields zero, so shamt=0 reduces to b.
            2'd3: w_b_shifted = (r_s0_b >> r_s0_shamt)
                              | (r_s0_b << (6'd32 - {1'b0, r_s0_shamt}));
            default: w_b_shifted = r_s0_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s0_shdir <= shdir_i;
            r_s0_shamt <= shamt_i;
        end
    end
`else
    logic w_unused_shift;
    assign w_unused_shift = ^{shdir_i, shamt_i};
    assign w_b_shifted    = r_s0_b;
`endif

    // Control state: valid bits, result register, flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_s0_valid <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_rd    <= '0;
            r_flags    <= FLAGS_RST;
        end else if (flush_i) begin
            r_s0_valid <= 1'b0;
            r_s1_valid <= 1'b0;
        end else begin
            if (w_s0_adv && r_s0_fl_we) begin
                r_flags <= alu_fl_i;
            end

            // A loading advance overrides the drain of the previous result.
            if (w_s0_adv && r_s0_wb_en) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= alu_r_i;
                r_s1_rd    <= r_s0_rd;
            end else if (w_wb_fire) begin
                r_s1_valid <= 1'b0;
            end

            if (w_accept) begin
                r_s0_valid <= 1'b1;
            end else if (w_s0_adv) begin
                r_s0_valid <= 1'b0;
            end
        end
    end

    // NOTE: the S0 payload has no reset; it is only meaningful while
    // r_s0_valid is set, and leaving it unreset keeps the datapath plain.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s0_op    <= op_i;
            r_s0_a     <= a_i;
            r_s0_b     <= b_i;
            r_s0_rd    <= rd_i;
            r_s0_wb_en <= wb_en_i;
            r_s0_fl_we <= fl_we_i;
        end
    end

    assign alu_a_o    = r_s0_a;
    assign alu_b_o    = w_b_shifted;
    assign alu_op_o   = r_s0_op;
    assign alu_fl_o   = r_flags;
    assign wb_valid_o = r_s1_valid;
    assign wb_rd_o    = r_s1_rd;
    assign wb_data_o  = r_s1_data;
    assign flags_o    = r_flags;

endmodule

// File: tb/tb_hs32_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_hs32_exec_stage
//
// Directed bench for hs32_exec_stage. The bench supplies the combinational
// ALU, keeps a transaction-level model (queue of issued-but-not-executed ops
// and queue of pending writebacks) and compares every DUT output against it
// on each falling edge. Literal expectations pin the model at key points.
// Honours HS32_EXEC_SHIFT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_hs32_exec_stage;

    localparam logic [3:0] FLAGS_RST = 4'b1010;

    localparam logic [3:0] HS32A_ADD = 4'd0;
    localparam logic [3:0] HS32A_SUB = 4'd1;
    localparam logic [3:0] HS32A_AND = 4'd2;
    localparam logic [3:0] HS32A_ADC = 4'd3;
    localparam logic [3:0] HS32A_MOV = 4'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [3:0]  rd_i;
    logic        wb_en_i;
    logic        fl_we_i;
    logic [1:0]  shdir_i;
    logic [4:0]  shamt_i;
    logic        flush_i;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [3:0]  alu_op_o;
    logic [3:0]  alu_fl_o;
    logic [31:0] alu_r_i;
    logic [3:0]  alu_fl_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [3:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic [3:0]  flags_o;

    int total = 0;
    int bad   = 0;

    hs32_exec_stage #(.FLAGS_RST(FLAGS_RST)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .rd_i       (rd_i),
        .wb_en_i    (wb_en_i),
        .fl_we_i    (fl_we_i),
        .shdir_i    (shdir_i),
        .shamt_i    (shamt_i),
        .flush_i    (flush_i),
        .alu_a_o    (alu_a_o),
        .alu_b_o    (alu_b_o),
        .alu_op_o   (alu_op_o),
        .alu_fl_o   (alu_fl_o),
        .alu_r_i    (alu_r_i),
        .alu_fl_i   (alu_fl_i),
        .wb_valid_o (wb_valid_o),
        .wb_ready_i (wb_ready_i),
        .wb_rd_o    (wb_rd_o),
        .wb_data_o  (wb_data_o),
        .flags_o    (flags_o)
    );

    always #5 clk = ~clk;

    // ALU behaviour: returns {nzcv, result}. Carry on SUB means "no borrow".
    function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] fl);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        s = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            HS32A_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            HS32A_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[31:0];
                c = !s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            HS32A_ADC: begin
                s = {1'b0, a} + {1'b0, b} + {32'd0, fl[1]};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            HS32A_AND: r = a & b;
            default:   r = b;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    always_comb begin
        {alu_fl_i, alu_r_i} = alu_f(alu_op_o, alu_a_o, alu_b_o, alu_fl_o);
    end

    // Expected operand B, written bit by bit from the shift definitions.
    function automatic logic [31:0] exp_b(input logic [31:0] b, input logic [1:0] dir,
                                          input logic [4:0] amt);
        logic [31:0] r;
        r = b;
`ifdef HS32_EXEC_SHIFT_EN
        for (int i = 0; i < 32; i++) begin
            case (dir)
                2'd0: r[i] = (i >= int'(amt)) ? b[i - int'(amt)] : 1'b0;
                2'd1: r[i] = (i + int'(amt) < 32) ? b[i + int'(amt)] : 1'b0;
                2'd2: r[i] = (i + int'(amt) < 32) ? b[i + int'(amt)] : b[31];
                default: r[i] = b[(i + int'(amt)) % 32];
            endcase
        end
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rd;
        logic        wb_en;
        logic        fl_we;
        logic [1:0]  shdir;
        logic [4:0]  shamt;
    } op_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  rd;
    } wb_t;

    op_t        exq[$];
    wb_t        wbq[$];
    logic [3:0] m_flags = FLAGS_RST;

    // Inputs change only just after a rising edge, so the falling edge sees
    // the values the next rising edge will sample.
    always @(negedge clk) begin
        logic        head_exec;
        logic        exp_ready;
        logic [35:0] res;
        op_t         o;
        wb_t         w;

        head_exec = (exq.size() != 0) && (!exq[0].wb_en || wbq.size() == 0 || wb_ready_i);
        exp_ready = !flush_i && (exq.size() == 0 || head_exec);

        check("m_ready", {31'd0, ready_o}, {31'd0, exp_ready});
        check("m_wb_valid", {31'd0, wb_valid_o}, {31'd0, (wbq.size() != 0)});
        if (wbq.size() != 0) begin
            check("m_wb_data", wb_data_o, wbq[0].data);
            check("m_wb_rd", {28'd0, wb_rd_o}, {28'd0, wbq[0].rd});
        end
        check("m_flags", {28'd0, flags_o}, {28'd0, m_flags});
        if (exq.size() != 0) begin
            check("m_alu_a", alu_a_o, exq[0].a);
            check("m_alu_b", alu_b_o, exp_b(exq[0].b, exq[0].shdir, exq[0].shamt));
            check("m_alu_op", {28'd0, alu_op_o}, {28'd0, exq[0].op});
            check("m_alu_fl", {28'd0, alu_fl_o}, {28'd0, m_flags});
        end

        if (reset) begin
            exq.delete();
            wbq.delete();
            m_flags = FLAGS_RST;
        end else if (flush_i) begin
            exq.delete();
            wbq.delete();
        end else begin
            if (wbq.size() != 0 && wb_ready_i) void'(wbq.pop_front());
            if (head_exec) begin
                o   = exq.pop_front();
                res = alu_f(o.op, o.a, exp_b(o.b, o.shdir, o.shamt), m_flags);
                if (o.fl_we) m_flags = res[35:32];
                if (o.wb_en) begin
                    w.data = res[31:0];
                    w.rd   = o.rd;
                    wbq.push_back(w);
                end
            end
            if (valid_i && exp_ready) begin
                o.op = op_i; o.a = a_i; o.b = b_i; o.rd = rd_i;
                o.wb_en = wb_en_i; o.fl_we = fl_we_i; o.shdir = shdir_i; o.shamt = shamt_i;
                exq.push_back(o);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] rd, input logic wb_en, input logic fl_we,
                         input logic [1:0] dir, input logic [4:0] amt);
        valid_i = 1'b1;
        op_i = op; a_i = a; b_i = b; rd_i = rd;
        wb_en_i = wb_en; fl_we_i = fl_we; shdir_i = dir; shamt_i = amt;
    endtask

    task automatic idle();
        valid_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1; valid_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b1;
        op_i = '0; a_i = '0; b_i = '0; rd_i = '0;
        wb_en_i = 1'b0; fl_we_i = 1'b0; shdir_i = '0; shamt_i = '0;

        // Reset state
        step(); step();
        check("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);
        check("rst_wb_rd", {28'd0, wb_rd_o}, 32'd0);
        check("rst_flags", {28'd0, flags_o}, {28'd0, FLAGS_RST});
        reset = 1'b0;
        #1;
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        step();

        // ADD 5+7 -> 12, nzcv 0000, one edge after accept
        drive(HS32A_ADD, 32'd5, 32'd7, 4'd1, 1'b1, 1'b1, 2'd0, 5'd0);
        step(); idle();
        check("add_alu_a", alu_a_o, 32'd5);
        step();
        check("add_wb_valid", {31'd0, wb_valid_o}, 32'd1);
        check("add_wb_data", wb_data_o, 32'd12);
        check("add_wb_rd", {28'd0, wb_rd_o}, 32'd1);
        check("add_flags", {28'd0, flags_o}, 32'b0000);
        step();

        // SUB 3-3 sets z (and c), next ADD sees it without changing flags
        drive(HS32A_SUB, 32'd3, 32'd3, 4'd2, 1'b1, 1'b1, 2'd0, 5'd0);
        step();
        drive(HS32A_ADD, 32'd1, 32'd1, 4'd3, 1'b1, 1'b0, 2'd0, 5'd0);
        step(); idle();
        check("sub_flags", {28'd0, flags_o}, 32'b0110);
        check("dep_alu_fl_z", {31'd0, alu_fl_o[2]}, 32'd1);
        check("dep_alu_op", {28'd0, alu_op_o}, {28'd0, HS32A_ADD});
        check("sub_wb_data", wb_data_o, 32'd0);
        step();
        check("dep_wb_data", wb_data_o, 32'd2);
        check("dep_flags_hold", {28'd0, flags_o}, 32'b0110);
        step();

        // Backpressure: three ops with writeback stalled
        wb_ready_i = 1'b0;
        drive(HS32A_MOV, 32'd0, 32'd11, 4'd4, 1'b1, 1'b0, 2'd0, 5'd0);
        step();
        drive(HS32A_MOV, 32'd0, 32'd22, 4'd5, 1'b1, 1'b0, 2'd0, 5'd0);
        step();
        check("bp_ready_low", {31'd0, ready_o}, 32'd0);
        check("bp_hold1", wb_data_o, 32'd11);
        drive(HS32A_MOV, 32'd0, 32'd33, 4'd6, 1'b1, 1'b0, 2'd0, 5'd0);
        step();
        check("bp_hold2", wb_data_o, 32'd11);
        check("bp_hold_rd", {28'd0, wb_rd_o}, 32'd4);
        step();
        check("bp_hold3", wb_data_o, 32'd11);
        wb_ready_i = 1'b1;
        #1;
        check("bp_ready_back", {31'd0, ready_o}, 32'd1);
        step(); idle();
        check("bp_second", wb_data_o, 32'd22);
        step();
        check("bp_third", wb_data_o, 32'd33);
        check("bp_third_rd", {28'd0, wb_rd_o}, 32'd6);
        step();
        check("bp_drained", {31'd0, wb_valid_o}, 32'd0);

        // Operand-B shifter (or pass-through when not built in)
        drive(HS32A_MOV, 32'd0, 32'h8000_0000, 4'd1, 1'b1, 1'b0, 2'd2, 5'd4);
        step();
        drive(HS32A_MOV, 32'd0, 32'h0000_000F, 4'd2, 1'b1, 1'b0, 2'd3, 5'd4);
        step();
`ifdef HS32_EXEC_SHIFT_EN
        check("sh_asr4", wb_data_o, 32'hF800_0000);
`else
        check("sh_off_asr", wb_data_o, 32'h8000_0000);
`endif
        drive(HS32A_MOV, 32'd0, 32'h1234_5678, 4'd3, 1'b1, 1'b0, 2'd1, 5'd0);
        step(); idle();
`ifdef HS32_EXEC_SHIFT_EN
        check("sh_ror4", wb_data_o, 32'hF000_0000);
`else
        check("sh_off_ror", wb_data_o, 32'h0000_000F);
`endif
        step();
        check("sh_amt0", wb_data_o, 32'h1234_5678);
        step();

        // Carry produced by one op consumed by the very next (ADC)
        drive(HS32A_ADD, 32'hFFFF_FFFF, 32'd1, 4'd4, 1'b1, 1'b1, 2'd0, 5'd0);
        step();
        drive(HS32A_ADC, 32'd1, 32'd1, 4'd5, 1'b1, 1'b0, 2'd0, 5'd0);
        step(); idle();
        check("adc_flags", {28'd0, flags_o}, 32'b0110);
        check("adc_alu_c", {31'd0, alu_fl_o[1]}, 32'd1);
        step();
        check("adc_wb_data", wb_data_o, 32'd3);
        step();

        // Flush with both stages occupied and a new op offered
        wb_ready_i = 1'b0;
        drive(HS32A_MOV, 32'd0, 32'h8000_0000, 4'd7, 1'b1, 1'b1, 2'd0, 5'd0);
        step();
        drive(HS32A_ADD, 32'd0, 32'd0, 4'd8, 1'b1, 1'b1, 2'd0, 5'd0);
        step();
        check("fl_pre_valid", {31'd0, wb_valid_o}, 32'd1);
        check("fl_pre_flags", {28'd0, flags_o}, 32'b1000);
        flush_i = 1'b1;
        drive(HS32A_MOV, 32'd0, 32'd99, 4'd9, 1'b1, 1'b1, 2'd0, 5'd0);
        #1;
        check("fl_ready_low", {31'd0, ready_o}, 32'd0);
        step();
        flush_i = 1'b0; idle();
        #1;
        check("fl_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        check("fl_flags", {28'd0, flags_o}, 32'b1000);
        check("fl_ready", {31'd0, ready_o}, 32'd1);
        wb_ready_i = 1'b1;
        step();
        check("fl_no_accept", {31'd0, wb_valid_o}, 32'd0);

        // Reset while a writeback is stalled
        wb_ready_i = 1'b0;
        drive(HS32A_MOV, 32'd0, 32'd55, 4'd8, 1'b1, 1'b1, 2'd0, 5'd0);
        step();
        drive(HS32A_MOV, 32'd0, 32'd66, 4'd9, 1'b1, 1'b1, 2'd0, 5'd0);
        step(); idle();
        check("mr_pre_valid", {31'd0, wb_valid_o}, 32'd1);
        check("mr_pre_data", wb_data_o, 32'd55);
        reset = 1'b1;
        step();
        check("mr_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        check("mr_flags", {28'd0, flags_o}, {28'd0, FLAGS_RST});
        check("mr_wb_data", wb_data_o, 32'd0);
        check("mr_ready", {31'd0, ready_o}, 32'd1);
        reset = 1'b0; wb_ready_i = 1'b1;
        step();
        check("mr_after_valid", {31'd0, wb_valid_o}, 32'd0);
        check("mr_after_ready", {31'd0, ready_o}, 32'd1);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
